// File: rtl/gpu_pkg.sv
// Constants shared by the GPU register file, the rasterizer and the memory loader.
// Also holds the loader's state encoding.
package gpu_pkg;

    localparam int GPU_ADDR_WIDTH     = 6;
    localparam int GPU_MEM_SIZE       = 64;
    localparam int GPU_DATA_WIDTH     = 16;
    localparam int GPU_MEM_ADDR_WIDTH = 13;
    localparam logic [GPU_MEM_ADDR_WIDTH-1:0] GPU_BASE_ADDR = 13'h1FC0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        COPY,
        DRAIN,
        DONE
    } loader_state_t;

endpackage

// File: rtl/gpu_mem_loader.sv
// Per-frame bulk copy of SIZE data-RAM words into GPU memory slots 0..SIZE-1.
// Ownership of the RAM read port is requested on start and released in DONE.
module gpu_mem_loader
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH     = GPU_ADDR_WIDTH,
    parameter int SIZE           = GPU_MEM_SIZE,
    parameter int DATA_WIDTH     = GPU_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = GPU_MEM_ADDR_WIDTH,
    parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = GPU_BASE_ADDR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      req,
    input  logic                      ack,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_dout,
    output logic                      gpu_we,
    output logic [ADDR_WIDTH-1:0]     gpu_addr,
    output logic [DATA_WIDTH-1:0]     gpu_din,
    output logic                      busy,
    output logic                      done
);

    loader_state_t             state, state_n;
    logic [ADDR_WIDTH:0]       k, k_n, k_inc;
    logic                      req_n, busy_n, done_n, we_n;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_n;
    logic [ADDR_WIDTH-1:0]     gpu_addr_n;

    assign k_inc = k + (ADDR_WIDTH+1)'(1);

    always_comb begin
        state_n    = state;
        k_n        = k;
        req_n      = req;
        busy_n     = busy;
        done_n     = 1'b0;
        we_n       = 1'b0;
        mem_addr_n = mem_addr;
        gpu_addr_n = gpu_addr;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = WAIT_ACK;
                    req_n   = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    state_n    = COPY;
                    mem_addr_n = BASE_ADDR;
                    k_n        = '0;
                end
            end
            COPY: begin
                // Address k was presented last cycle, so its data lands in slot k now.
                we_n       = 1'b1;
                gpu_addr_n = k[ADDR_WIDTH-1:0];
                if (k == (ADDR_WIDTH+1)'(SIZE-1)) begin
                    state_n = DRAIN;
                end else begin
                    k_n        = k_inc;
                    mem_addr_n = BASE_ADDR + MEM_ADDR_WIDTH'(k_inc);
                end
            end
            DRAIN: begin
                state_n = DONE;
                done_n  = 1'b1;
                req_n   = 1'b0;
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            req      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gpu_we   <= 1'b0;
            mem_addr <= '0;
            gpu_addr <= '0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            req      <= req_n;
            busy     <= busy_n;
            done     <= done_n;
            gpu_we   <= we_n;
            mem_addr <= mem_addr_n;
            gpu_addr <= gpu_addr_n;
        end
    end

    assign gpu_din = gpu_we ? mem_dout : '0;

endmodule

// File: tb/tb_gpu_mem_loader.sv
// Randomized bench for gpu_mem_loader with a RAM model, a GPU memory model and
// an array-level expectation of the GPU memory contents after each frame.
module tb_gpu_mem_loader;
    import gpu_pkg::*;

    localparam int N    = 64;
    localparam int BASE = 'h1FC0;

    logic        clk = 1'b0;
    logic        reset, start, ack;
    logic        req, gpu_we, busy, done;
    logic [12:0] mem_addr;
    logic [15:0] mem_dout, gpu_din;
    logic [5:0]  gpu_addr;

    always #5 clk = ~clk;

    gpu_mem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .req      (req),
        .ack      (ack),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .gpu_we   (gpu_we),
        .gpu_addr (gpu_addr),
        .gpu_din  (gpu_din),
        .busy     (busy),
        .done     (done)
    );

    logic [15:0] ram     [0:8191];
    logic [15:0] gmem    [0:N-1];
    logic [15:0] exp_mem [0:N-1];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    bit          addr_oob = 1'b0;

    // Synchronous-read data RAM and write-port GPU memory
    always @(posedge clk) begin
        mem_dout <= ram[mem_addr];
        if (gpu_we) begin
            gmem[gpu_addr] <= gpu_din;
            wr_addr_q.push_back(int'(gpu_addr));
            wr_data_q.push_back(gpu_din);
            if (int'(mem_addr) < BASE || int'(mem_addr) > BASE + N - 1) addr_oob = 1'b1;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       ram[BASE+i] = 16'(16'hA000 + i);
                1:       ram[BASE+i] = 16'(16'hB000 + i);
                2:       ram[BASE+i] = 16'(16'hD000 + i);
                default: ram[BASE+i] = 16'($urandom);
            endcase
        end
    endtask

    task automatic compare_gmem(input string tag);
        int bad = 0;
        for (int i = 0; i < N; i++)
            if (gmem[i] !== exp_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    // One complete frame; the done pulse must appear in the 66th cycle after the ack edge.
    task automatic run_frame(input int ack_delay, input bit poke_start);
        int dc0, n, done_at, bad;
        bit wait_bad;
        wr_addr_q.delete();
        wr_data_q.delete();
        dc0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check("req_on_start", req, 1);
        check("busy_on_start", busy, 1);
        wait_bad = 1'b0;
        repeat (ack_delay) begin
            step();
            if (!(req === 1'b1 && busy === 1'b1 && gpu_we === 1'b0)) wait_bad = 1'b1;
        end
        check("wait_ack_hold", wait_bad, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        n = 1;
        done_at = 0;
        while (n < 200 && done_at == 0) begin
            if (done === 1'b1) begin
                done_at = n;
            end else begin
                if (poke_start && n == 11) start = 1'b1;
                step();
                start = 1'b0;
                n++;
            end
        end
        check("done_latency", done_at, 66);
        check("busy_in_done", busy, 1);
        check("req_in_done", req, 0);
        if (poke_start) start = 1'b1;
        step();
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_req", req, 0);
        check("done_once", done_cnt - dc0, 1);
        check("din_gated", gpu_din, 0);
        check("wr_count", wr_addr_q.size(), N);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_data_q[i] !== ram[BASE+i]) bad++;
        check("wr_sequence", bad, 0);
        for (int i = 0; i < N; i++) exp_mem[i] = ram[BASE+i];
        compare_gmem("gmem_after_frame");
    endtask

    task automatic reset_mid_copy(input int stop_slot);
        int n, dc0;
        bit hit;
        dc0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat ($urandom_range(0, 5)) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        n = 0;
        hit = 1'b0;
        while (n < 200 && !hit) begin
            if (gpu_we === 1'b1 && int'(gpu_addr) == stop_slot) hit = 1'b1;
            else begin
                step();
                n++;
            end
        end
        check("reach_stop_slot", hit, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_req", req, 0);
        check("rst_we", gpu_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_gpu_addr", gpu_addr, 0);
        repeat (80) step();
        check("rst_no_done", done_cnt - dc0, 0);
        for (int i = 0; i <= stop_slot; i++) exp_mem[i] = ram[BASE+i];
        compare_gmem("gmem_after_abort");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        for (int i = 0; i < 8192; i++) ram[i] = 16'(i * 7 + 3);
        for (int i = 0; i < N; i++) begin
            gmem[i]    = 16'(16'h5000 + i);
            exp_mem[i] = 16'(16'h5000 + i);
        end
        repeat (3) step();
        check("reset_req", req, 0);
        check("reset_we", gpu_we, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_gpu_addr", gpu_addr, 0);
        check("reset_din_gated", gpu_din, 0);
        reset = 1'b0;
        step();

        // Nominal, long grant delay, ignored starts plus back-to-back restart
        fill_ram(0);
        run_frame(3, 1'b0);
        run_frame(100, 1'b0);
        fill_ram(3);
        run_frame($urandom_range(0, 8), 1'b1);
        fill_ram(3);
        run_frame($urandom_range(0, 8), 1'b0);

        // Abort after slot 20, then a clean frame
        fill_ram(2);
        reset_mid_copy(20);
        fill_ram(0);
        run_frame(2, 1'b0);

        // Changing RAM contents between frames
        fill_ram(1);
        run_frame(0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            fill_ram(3);
            run_frame($urandom_range(0, 20), 1'b0);
        end

        // Reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check("prio_req", req, 0);
        check("prio_busy", busy, 0);
        step();
        check("prio_still_idle", req, 0);

        check("mem_addr_range", addr_oob, 0);
        compare_gmem("gmem_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
